// File: rtl/turf_trigger_arbiter_pkg.sv
// Shared types for the TURF trigger arbiter: FSM state encoding and index-width helper.
// No logic; no latency or backpressure of its own.
package turf_trigger_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Index width that never collapses to zero for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turf_trigger_arbiter_conditioner.sv
// Per-source edge detect, enable gate and prescaler feeding a one-deep pending flag.
// Pending is set one cycle after the edge; a forwarded edge that finds pending already set is dropped.
module turf_trigger_arbiter_conditioner #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  trig_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  grant_i,
  output logic                  pending_o,
  output logic                  drop_o
);

  logic                  trig_q;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  edge_s, fwd_s;

  assign edge_s = trig_i & ~trig_q & en_i;
  assign fwd_s  = edge_s & (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)       cnt_d = '0;
    else if (fwd_s)  cnt_d = '0;
    else if (edge_s) cnt_d = cnt_q + PRESCALE_W'(1);
  end

  // A grant in the same cycle frees the slot, so a coincident edge replaces it rather than dropping.
  assign pending_d = en_i & ((pending_q & ~grant_i) | fwd_s);
  assign drop_o    = en_i & fwd_s & pending_q & ~grant_i;
  assign pending_o = pending_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_q    <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      trig_q    <= trig_i;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/turf_trigger_arbiter.sv
// Merges conditioned trigger sources, allocates SURF buffers in ring order and issues {epoch,count} records.
// Edge-to-valid is two cycles; record held stable until trig_ready_i, then HOLDOFF dead cycles.
module turf_trigger_arbiter
  import turf_trigger_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int NUM_BUFFERS = 4,
  parameter int EVID_WIDTH  = 32,
  parameter int EPOCH_WIDTH = 12,
  parameter int PRESCALE_W  = 8,
  parameter int HOLDOFF     = 16,
  parameter int LOST_W      = 16,
  localparam int SW = idx_w(NUM_SOURCES),
  localparam int BW = idx_w(NUM_BUFFERS)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_SOURCES-1:0]            trig_i,
  input  logic [NUM_SOURCES-1:0]            en_i,
  input  logic [NUM_SOURCES*PRESCALE_W-1:0] prescale_i,
  input  logic                              disable_i,
  input  logic [EPOCH_WIDTH-1:0]            epoch_i,
  input  logic                              evid_reset_i,
  input  logic                              clr_evt_i,
  input  logic [BW-1:0]                     clr_buf_i,
  output logic [NUM_BUFFERS-1:0]            hold_o,
  output logic                              trig_valid_o,
  input  logic                              trig_ready_i,
  output logic [SW-1:0]                     trig_src_o,
  output logic [BW-1:0]                     trig_buf_o,
  output logic [EVID_WIDTH-1:0]             evid_o,
  output logic [EVID_WIDTH-1:0]             next_id_o,
  output logic                              full_o,
  output logic [LOST_W-1:0]                 lost_o
);

  localparam int CW = EVID_WIDTH - EPOCH_WIDTH;
  localparam int HW = idx_w(HOLDOFF);
  localparam int DW = idx_w(NUM_SOURCES + 1);
  localparam logic [HW-1:0] HO_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_t                 state_q, state_d;
  logic [BW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_BUFFERS-1:0] hold_q, hold_d;
  logic [SW-1:0]          src_q, src_d;
  logic [BW-1:0]          buf_q, buf_d;
  logic [EVID_WIDTH-1:0]  evid_q, evid_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic                   evr_q, evr_d;
  logic [LOST_W-1:0]      lost_q, lost_d;

  logic [NUM_SOURCES-1:0] pending, drop, grant;
  logic [SW-1:0]          sel;
  logic [DW-1:0]          ndrop;
  logic [LOST_W:0]        lost_sum;
  logic                   clr_same, alloc;

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_cond
    turf_trigger_arbiter_conditioner #(.PRESCALE_W(PRESCALE_W)) u_cond (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .trig_i     (trig_i[s]),
      .en_i       (en_i[s]),
      .prescale_i (prescale_i[s*PRESCALE_W +: PRESCALE_W]),
      .grant_i    (grant[s]),
      .pending_o  (pending[s]),
      .drop_o     (drop[s])
    );
  end

  always_comb begin
    sel = '0;
    for (int s = NUM_SOURCES - 1; s >= 0; s--) begin
      if (pending[s]) sel = SW'(s);
    end
  end

  always_comb begin
    ndrop = '0;
    for (int s = 0; s < NUM_SOURCES; s++) ndrop = ndrop + DW'(drop[s]);
  end

  assign lost_sum = {1'b0, lost_q} + (LOST_W + 1)'(ndrop);
  assign lost_d   = lost_sum[LOST_W] ? '1 : lost_sum[LOST_W-1:0];

  // Only the ring head is allocatable; a release aimed at it this cycle defers allocation by one cycle.
  assign full_o   = hold_q[wr_ptr_q];
  assign clr_same = clr_evt_i && (clr_buf_i == wr_ptr_q);
  assign alloc    = (state_q == ST_IDLE) && (|pending) && !disable_i && !full_o && !clr_same;
  assign grant    = alloc ? (NUM_SOURCES'(1) << sel) : '0;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    src_d    = src_q;
    buf_d    = buf_q;
    evid_d   = evid_q;
    hcnt_d   = hcnt_q;
    evr_d    = evr_q;
    if (clr_evt_i) hold_d[clr_buf_i] = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (alloc) begin
          hold_d[wr_ptr_q] = 1'b1;
          src_d   = sel;
          buf_d   = wr_ptr_q;
          evid_d  = {epoch_i, cnt_q};
          evr_d   = evid_reset_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (evid_reset_i) evr_d = 1'b1;
        if (trig_ready_i) begin
          wr_ptr_d = wr_ptr_q + BW'(1);
          // An ID reset seen during this record means the count already restarted at 0 for the next one.
          if (!evr_q && !evid_reset_i) cnt_d = cnt_q + CW'(1);
          evr_d   = 1'b0;
          hcnt_d  = '0;
          state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == HO_LAST) state_d = ST_IDLE;
        else                   hcnt_d  = hcnt_q + HW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (evid_reset_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      src_q    <= '0;
      buf_q    <= '0;
      evid_q   <= '0;
      hcnt_q   <= '0;
      evr_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      src_q    <= src_d;
      buf_q    <= buf_d;
      evid_q   <= evid_d;
      hcnt_q   <= hcnt_d;
      evr_q    <= evr_d;
      lost_q   <= lost_d;
    end
  end

  assign hold_o       = hold_q;
  assign trig_valid_o = (state_q == ST_ISSUE);
  assign trig_src_o   = src_q;
  assign trig_buf_o   = buf_q;
  assign evid_o       = evid_q;
  assign next_id_o    = {epoch_i, cnt_q};
  assign lost_o       = lost_q;

endmodule
